// File: rtl/morse_key_classifier.sv
// rtl/morse_key_classifier.sv - debounced Morse key to dot/dash letter classifier
// Collects up to five symbols per letter and presents them through a valid/ready output register.
module morse_key_classifier #(
  parameter int unsigned DEBOUNCE_CYC = 500_000,
  parameter int unsigned DOT_MAX_CYC  = 12_500_000,
  parameter int unsigned GAP_CYC      = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_n,
  input  logic       enable,
  input  logic       ready_in,
  output logic       valid_out,
  output logic [4:0] code_out,
  output logic [2:0] len_out,
  output logic       busy,
  output logic       err_o,
  output logic       drop_o
);

  localparam int            CW       = 26;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] DOT_MAX  = CW'(DOT_MAX_CYC);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t        state;
  state_t        state_next;
  logic          key_meta;
  logic          key_s;
  logic          key_db;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] press_cnt;
  logic [CW-1:0] gap_cnt;
  logic [4:0]    shift;
  logic [2:0]    count;
  logic [4:0]    len_mask;
  logic          sym_done;
  logic          letter_done;

  assign busy     = (state != IDLE);
  assign len_mask = 5'((6'd1 << count) - 6'd1);

  // The raw key is sampled twice before the debouncer ever sees it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
      key_db   <= 1'b1;
      db_cnt   <= '0;
    end else begin
      key_meta <= key_n;
      key_s    <= key_meta;
      if (key_s == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= key_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    sym_done    = 1'b0;
    letter_done = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!key_db) state_next = PRESS;
        end
        PRESS: begin
          if (key_db) begin
            state_next = GAP;
            sym_done   = 1'b1;
          end
        end
        GAP: begin
          if (!key_db) begin
            state_next = PRESS;
          end else if (gap_cnt == GAP_LAST) begin
            state_next  = IDLE;
            letter_done = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_cnt <= '0;
      gap_cnt   <= '0;
      shift     <= '0;
      count     <= '0;
    end else if (!enable) begin
      press_cnt <= '0;
      gap_cnt   <= '0;
      shift     <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: press_cnt <= '0;
        PRESS: begin
          if (sym_done) begin
            shift   <= {shift[3:0], (press_cnt >= DOT_MAX)};
            count   <= (count == 3'd6) ? count : count + 3'd1;
            gap_cnt <= '0;
          end else if (press_cnt != CNT_MAX) begin
            press_cnt <= press_cnt + ONE;
          end
        end
        GAP: begin
          if (!key_db) begin
            press_cnt <= '0;
          end else if (letter_done) begin
            shift   <= '0;
            count   <= '0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + ONE;
          end
        end
        default: press_cnt <= '0;
      endcase
    end
  end

  // Count 6 means the letter overflowed; an occupied, stalled output drops the new letter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out <= 1'b0;
      code_out  <= '0;
      len_out   <= '0;
      err_o     <= 1'b0;
      drop_o    <= 1'b0;
    end else begin
      err_o  <= 1'b0;
      drop_o <= 1'b0;
      if (valid_out && ready_in) valid_out <= 1'b0;
      if (letter_done) begin
        if (count == 3'd6) begin
          err_o <= 1'b1;
        end else if (!valid_out || ready_in) begin
          valid_out <= 1'b1;
          code_out  <= shift & len_mask;
          len_out   <= count;
        end else begin
          drop_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_morse_key_classifier.sv
// tb/tb_morse_key_classifier.sv - randomized self-checking bench for morse_key_classifier
module tb_morse_key_classifier;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b1;
  logic       key_n    = 1'b1;
  logic       enable   = 1'b1;
  logic       ready_in = 1'b1;
  logic       valid_out;
  logic [4:0] code_out;
  logic [2:0] len_out;
  logic       busy;
  logic       err_o;
  logic       drop_o;

  int passed   = 0;
  int failed   = 0;
  int total    = 0;
  int err_cnt  = 0;
  int drop_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  morse_key_classifier #(
    .DEBOUNCE_CYC(4),
    .DOT_MAX_CYC (20),
    .GAP_CYC     (50)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .key_n    (key_n),
    .enable   (enable),
    .ready_in (ready_in),
    .valid_out(valid_out),
    .code_out (code_out),
    .len_out  (len_out),
    .busy     (busy),
    .err_o    (err_o),
    .drop_o   (drop_o)
  );

  // Inputs change on the falling edge; this sees what the next rising edge will act on.
  always @(negedge clk) begin
    #1;
    if (valid_out && ready_in) got_q.push_back({len_out, code_out});
    if (err_o) err_cnt++;
    if (drop_o) drop_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_letter(input string tag, input int idx, input logic [7:0] exp);
    logic [7:0] g;
    g = (idx < got_q.size()) ? got_q[idx] : 8'hFF;
    check(tag, g, exp);
  endtask

  task automatic hold(input logic v, input int n);
    @(negedge clk);
    key_n = v;
    repeat (n - 1) @(negedge clk);
  endtask

  // dash[i] is the i-th symbol keyed; the last release is the letter gap.
  task automatic send_letter(input int n, input logic [5:0] dash, input bit rnd, input int lgap);
    for (int i = 0; i < n; i++) begin
      int plen;
      int glen;
      if (rnd) plen = dash[i] ? int'($urandom_range(40, 26)) : int'($urandom_range(14, 6));
      else     plen = dash[i] ? 30 : 10;
      glen = rnd ? int'($urandom_range(30, 6)) : 10;
      hold(1'b0, plen);
      hold(1'b1, (i == n - 1) ? lgap : glen);
    end
  endtask

  function automatic logic [7:0] ref_letter(input int n, input logic [5:0] dash);
    int code;
    code = 0;
    for (int i = 0; i < n; i++)
      if (dash[i]) code += 1 << (n - 1 - i);
    return {3'(n), 5'(code)};
  endfunction

  initial begin
    int base;
    int e0;
    int d0;
    int b0;
    int n;
    int exp_err;
    logic [5:0] d;
    logic [7:0] exp_q[$];

    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_code", code_out, 0);
    check("rst_len", len_out, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_o, 0);
    check("rst_drop", drop_o, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    base = got_q.size();
    e0 = err_cnt;
    d0 = drop_cnt;
    hold(1'b0, 10);
    check("e_busy", busy, 1);
    hold(1'b1, 60);
    check("e_count", got_q.size() - base, 1);
    check_letter("e_letter", base, {3'd1, 5'b00000});

    base = got_q.size();
    send_letter(2, 6'b000001, 1'b0, 60);
    check("n_count", got_q.size() - base, 1);
    check_letter("n_letter", base, {3'd2, 5'b00010});

    base = got_q.size();
    send_letter(5, 6'b011111, 1'b0, 60);
    check("five_count", got_q.size() - base, 1);
    check_letter("five_letter", base, {3'd5, 5'b11111});
    check("clean_err", err_cnt - e0, 0);
    check("clean_drop", drop_cnt - d0, 0);

    base = got_q.size();
    b0 = busy_cnt;
    repeat (3) begin
      hold(1'b0, 2);
      hold(1'b1, 10);
    end
    check("glitch_busy", busy_cnt - b0, 0);
    check("glitch_count", got_q.size() - base, 0);

    base = got_q.size();
    e0 = err_cnt;
    send_letter(6, 6'b000000, 1'b0, 60);
    check("six_err", err_cnt - e0, 1);
    check("six_count", got_q.size() - base, 0);

    base = got_q.size();
    d0 = drop_cnt;
    ready_in = 1'b0;
    send_letter(1, 6'b000000, 1'b0, 60);
    check("hold_valid", valid_out, 1);
    check("hold_len", len_out, 1);
    check("hold_code", code_out, 0);
    send_letter(1, 6'b000001, 1'b0, 60);
    check("drop_pulse", drop_cnt - d0, 1);
    check("drop_valid", valid_out, 1);
    check("drop_len", len_out, 1);
    check("drop_code", code_out, 0);
    @(negedge clk);
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    #1;
    check("accept_valid", valid_out, 0);
    check("accept_count", got_q.size() - base, 1);
    check_letter("accept_letter", base, {3'd1, 5'b00000});
    ready_in = 1'b1;

    base = got_q.size();
    e0 = err_cnt;
    d0 = drop_cnt;
    hold(1'b0, 8);
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    key_n = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_valid", valid_out, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    send_letter(1, 6'b000000, 1'b0, 60);
    check("rst_e_count", got_q.size() - base, 1);
    check_letter("rst_e_letter", base, {3'd1, 5'b00000});
    check("rst_e_err", err_cnt - e0, 0);
    check("rst_e_drop", drop_cnt - d0, 0);

    base = got_q.size();
    hold(1'b0, 30);
    hold(1'b1, 10);
    check("abort_busy_gap", busy, 1);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    hold(1'b1, 70);
    check("abort_count", got_q.size() - base, 0);

    base = got_q.size();
    e0 = err_cnt;
    d0 = drop_cnt;
    exp_err = 0;
    for (int k = 0; k < 25; k++) begin
      n = int'($urandom_range(6, 1));
      d = 6'($urandom);
      if (n == 6) exp_err++;
      else exp_q.push_back(ref_letter(n, d));
      send_letter(n, d, 1'b1, int'($urandom_range(80, 62)));
    end
    check("rnd_count", got_q.size() - base, exp_q.size());
    check("rnd_err", err_cnt - e0, exp_err);
    check("rnd_drop", drop_cnt - d0, 0);
    for (int k = 0; k < exp_q.size(); k++)
      check_letter($sformatf("rnd_letter%0d", k), base + k, exp_q[k]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
